// File: rtl/pwm_decoder.sv
// pwm_decoder: single-channel PWM demodulator. Measures high time and period of
// pwm_in in prescaled ticks and reports a RES-bit duty code once per period.
// Optional build macro PWM_DEC_GLITCH_EN adds a 3-clk stability filter after
// the synchroniser (latency 7 clk instead of 4, pulses under 3 clk ignored).
module pwm_decoder #(
  parameter int unsigned RES   = 8,
  parameter int unsigned FCLKM = 16000000,
  parameter int unsigned FS    = 10000,
  parameter int unsigned TOL   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  output logic [RES-1:0] d_out,
  output logic           valid,
  output logic           period_err,
  output logic           timeout
);

  localparam int unsigned NOM_PER = 2 ** RES;
  localparam int unsigned DIV_RAW = FCLKM / (FS * NOM_PER);
  localparam int unsigned DIV_N   = (DIV_RAW > 1) ? DIV_RAW : 1;
  localparam int unsigned PRE_W   = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int unsigned CNT_W   = RES + 2;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] NOM_C    = CNT_W'(NOM_PER);
  localparam logic [CNT_W-1:0] DMAX_C   = CNT_W'(NOM_PER - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(2 * NOM_PER - 1);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL);

  typedef enum logic {ST_SYNC, ST_MEAS} state_t;

  logic             meta;
  logic             sync;
  logic             lvl;
  logic             prev;
  logic             lvl_d;
  logic             rise_q;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_cnt, per_d;
  logic [CNT_W-1:0] hi_cnt, hi_d;
  logic [CNT_W-1:0] per_dev_c;
  logic [RES-1:0]   d_d;
  logic             valid_d;
  logic             err_d;
  logic             to_d;

  // Two-flop synchroniser for the asynchronous PWM input
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pwm_in;
      sync <= meta;
    end
  end

`ifdef PWM_DEC_GLITCH_EN
  logic       filt;
  logic [1:0] stab_cnt;

  // Filtered level follows sync only after it has held a new value for 3 clk
  always_ff @(posedge clk) begin
    if (rst) begin
      filt     <= 1'b0;
      stab_cnt <= 2'd0;
    end else if (sync != filt) begin
      if (stab_cnt == 2'd2) begin
        filt     <= sync;
        stab_cnt <= 2'd0;
      end else begin
        stab_cnt <= stab_cnt + 2'd1;
      end
    end else begin
      stab_cnt <= 2'd0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync;
`endif

  // Registered edge detect; lvl_d is the level aligned so the rise clk counts as low
  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= 1'b0;
      lvl_d  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev   <= lvl;
      lvl_d  <= prev;
      rise_q <= lvl & ~prev;
    end
  end

  // Prescaler: tick pulses once every DIV_N clk (every clk when DIV_N is 1)
  assign tick_c = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Absolute deviation of the measured period from the nominal 2^RES ticks
  always_comb begin
    per_dev_c = '0;
    if (per_cnt >= NOM_C) begin
      per_dev_c = per_cnt - NOM_C;
    end else begin
      per_dev_c = NOM_C - per_cnt;
    end
  end

  // Measurement FSM: next state, counters and result registers
  always_comb begin
    state_d = state_q;
    per_d   = per_cnt;
    hi_d    = hi_cnt;
    d_d     = d_out;
    valid_d = 1'b0;
    err_d   = period_err;
    to_d    = timeout;

    case (state_q)
      ST_SYNC: begin
        if (rise_q) begin
          state_d = ST_MEAS;
          per_d   = '0;
          hi_d    = '0;
        end
      end
      ST_MEAS: begin
        if (rise_q) begin
          d_d     = (hi_cnt > DMAX_C) ? '1 : hi_cnt[RES-1:0];
          err_d   = (per_dev_c > TOL_C);
          to_d    = 1'b0;
          valid_d = 1'b1;
          per_d   = '0;
          hi_d    = '0;
        end else if (tick_c && (per_cnt == TO_LAST)) begin
          d_d     = {RES{lvl_d}};
          err_d   = 1'b0;
          to_d    = 1'b1;
          valid_d = 1'b1;
          per_d   = '0;
          hi_d    = '0;
        end else if (tick_c) begin
          if (per_cnt != '1) begin
            per_d = per_cnt + 1'b1;
          end
          if (lvl_d && (hi_cnt != '1)) begin
            hi_d = hi_cnt + 1'b1;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      d_out      <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt    <= per_d;
      hi_cnt     <= hi_d;
      d_out      <= d_d;
      valid      <= valid_d;
      period_err <= err_d;
      timeout    <= to_d;
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed bench for pwm_decoder (RES=8, DIV_N=1).
module tb_pwm_decoder;

`ifdef PWM_DEC_GLITCH_EN
  localparam int unsigned LAT   = 7;
  localparam int unsigned SW_LO = 3;
  localparam int unsigned SW_HI = 253;
`else
  localparam int unsigned LAT   = 4;
  localparam int unsigned SW_LO = 1;
  localparam int unsigned SW_HI = 255;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] d_out;
  logic       valid;
  logic       period_err;
  logic       timeout;

  pwm_decoder #(
    .RES  (8),
    .FCLKM(2560000),
    .FS   (10000),
    .TOL  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .d_out     (d_out),
    .valid     (valid),
    .period_err(period_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned lat;
    logic [7:0]  d;
    logic        err;
    logic        to;
  } ev_t;

  ev_t         evq[$];
  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  int unsigned dbl_cnt = 0;
  logic        valid_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with its cycle and distance from the last driven rise
  always @(negedge clk) begin
    if (valid === 1'b1) evq.push_back('{cyc, cyc - last_rise, d_out, period_err, timeout});
    if (valid === 1'b1 && valid_prev === 1'b1) dbl_cnt++;
    valid_prev = valid;
  end

  task automatic drive(input logic v, input int n);
    if (v && !pwm_in) last_rise = cyc;
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic period(input int hi, input int tot);
    drive(1'b1, hi);
    drive(1'b0, tot - hi);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (d_out !== 8'd0) begin n_fail++; $display("FAIL reset_d_out: got %0d expected 0", d_out); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (period_err !== 1'b0) begin n_fail++; $display("FAIL reset_period_err: got %b expected 0", period_err); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    rst = 1'b0;
  endtask

  task automatic test_duty64();
    evq.delete();
    repeat (3) period(64, 256);
    n_checks++; if (evq.size() != 2) begin n_fail++; $display("FAIL duty64_count: got %0d expected 2", evq.size()); end
    foreach (evq[i]) begin
      n_checks++; if (evq[i].d !== 8'd64) begin n_fail++; $display("FAIL duty64_d[%0d]: got %0d expected 64", i, evq[i].d); end
      n_checks++; if (evq[i].err !== 1'b0 || evq[i].to !== 1'b0) begin n_fail++; $display("FAIL duty64_flags[%0d]: got err=%b to=%b expected 0 0", i, evq[i].err, evq[i].to); end
      n_checks++; if (evq[i].lat != LAT) begin n_fail++; $display("FAIL duty64_latency[%0d]: got %0d expected %0d", i, evq[i].lat, LAT); end
    end
  endtask

  task automatic test_sweep();
    int unsigned exp_d [4] = '{64, SW_LO, 128, SW_HI};
    evq.delete();
    period(int'(SW_LO), 256);
    period(128, 256);
    period(int'(SW_HI), 256);
    period(int'(SW_LO), 256);
    n_checks++; if (evq.size() != 4) begin n_fail++; $display("FAIL sweep_count: got %0d expected 4", evq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (evq[i].d !== 8'(exp_d[i])) begin n_fail++; $display("FAIL sweep_d[%0d]: got %0d expected %0d", i, evq[i].d, exp_d[i]); end
        n_checks++; if (evq[i].err !== 1'b0 || evq[i].to !== 1'b0) begin n_fail++; $display("FAIL sweep_flags[%0d]: got err=%b to=%b expected 0 0", i, evq[i].err, evq[i].to); end
        n_checks++; if (evq[i].lat != LAT) begin n_fail++; $display("FAIL sweep_latency[%0d]: got %0d expected %0d", i, evq[i].lat, LAT); end
      end
    end
  endtask

  task automatic test_timeout_low();
    int unsigned r0;
    r0 = last_rise;
    evq.delete();
    drive(1'b0, 1200);
    n_checks++; if (evq.size() != 2) begin n_fail++; $display("FAIL tlow_count: got %0d expected 2", evq.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (evq[i].cyc != r0 + LAT + 512 * (i + 1)) begin n_fail++; $display("FAIL tlow_cycle[%0d]: got %0d expected %0d", i, evq[i].cyc, r0 + LAT + 512 * (i + 1)); end
        n_checks++; if (evq[i].d !== 8'd0 || evq[i].to !== 1'b1 || evq[i].err !== 1'b0) begin n_fail++; $display("FAIL tlow_event[%0d]: got d=%0d to=%b err=%b expected 0 1 0", i, evq[i].d, evq[i].to, evq[i].err); end
      end
    end
    n_checks++; if (timeout !== 1'b1 || d_out !== 8'd0) begin n_fail++; $display("FAIL tlow_held: got timeout=%b d_out=%0d expected 1 0", timeout, d_out); end
  endtask

  task automatic test_timeout_high();
    int unsigned h;
    evq.delete();
    drive(1'b1, 1200);
    h = last_rise;
    n_checks++; if (evq.size() != 3) begin n_fail++; $display("FAIL thigh_count: got %0d expected 3", evq.size()); end
    else begin
      n_checks++; if (evq[0].cyc != h + LAT || evq[0].d !== 8'd0 || evq[0].err !== 1'b1 || evq[0].to !== 1'b0) begin n_fail++; $display("FAIL thigh_rise: got cyc=%0d d=%0d err=%b to=%b expected %0d 0 1 0", evq[0].cyc, evq[0].d, evq[0].err, evq[0].to, h + LAT); end
      for (int i = 1; i < 3; i++) begin
        n_checks++; if (evq[i].cyc != h + LAT + 512 * i) begin n_fail++; $display("FAIL thigh_cycle[%0d]: got %0d expected %0d", i, evq[i].cyc, h + LAT + 512 * i); end
        n_checks++; if (evq[i].d !== 8'd255 || evq[i].to !== 1'b1 || evq[i].err !== 1'b0) begin n_fail++; $display("FAIL thigh_event[%0d]: got d=%0d to=%b err=%b expected 255 1 0", i, evq[i].d, evq[i].to, evq[i].err); end
      end
    end
  endtask

  task automatic test_period_err();
    logic [7:0] exp_d [4] = '{8'd100, 8'd100, 8'd100, 8'd255};
    logic       exp_e [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    evq.delete();
    drive(1'b0, 10);
    period(100, 270);
    period(100, 258);
    period(100, 250);
    period(290, 300);
    period(100, 256);
    n_checks++; if (evq.size() != 5) begin n_fail++; $display("FAIL perr_count: got %0d expected 5", evq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (evq[i+1].d !== exp_d[i]) begin n_fail++; $display("FAIL perr_d[%0d]: got %0d expected %0d", i, evq[i+1].d, exp_d[i]); end
        n_checks++; if (evq[i+1].err !== exp_e[i] || evq[i+1].to !== 1'b0) begin n_fail++; $display("FAIL perr_err[%0d]: got err=%b to=%b expected %b 0", i, evq[i+1].err, evq[i+1].to, exp_e[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    evq.delete();
    drive(1'b1, 20);
    n_checks++; if (evq.size() != 1 || d_out !== 8'd100 || period_err !== 1'b0) begin n_fail++; $display("FAIL rmid_pre: got n=%0d d_out=%0d err=%b expected 1 100 0", evq.size(), d_out, period_err); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (d_out !== 8'd0 || valid !== 1'b0 || period_err !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rmid_clear: got d=%0d v=%b err=%b to=%b expected all 0", d_out, valid, period_err, timeout); end
    evq.delete();
    drive(1'b1, 107);
    drive(1'b0, 128);
    repeat (3) period(128, 256);
    n_checks++; if (evq.size() != 3) begin n_fail++; $display("FAIL rmid_count: got %0d expected 3", evq.size()); end
    else begin
      for (int i = 1; i < 3; i++) begin
        n_checks++; if (evq[i].d !== 8'd128 || evq[i].err !== 1'b0 || evq[i].to !== 1'b0) begin n_fail++; $display("FAIL rmid_event[%0d]: got d=%0d err=%b to=%b expected 128 0 0", i, evq[i].d, evq[i].err, evq[i].to); end
      end
    end
  endtask

  task automatic test_glitch();
    int unsigned g0;
`ifdef PWM_DEC_GLITCH_EN
    localparam int NEV = 3;
    int unsigned exp_c [3] = '{7, 263, 519};
    logic [7:0]  exp_d [3] = '{8'd128, 8'd128, 8'd128};
    logic        exp_e [3] = '{1'b0, 1'b0, 1'b0};
`else
    localparam int NEV = 4;
    int unsigned exp_c [4] = '{4, 46, 260, 516};
    logic [7:0]  exp_d [4] = '{8'd128, 8'd40, 8'd86, 8'd128};
    logic        exp_e [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
    evq.delete();
    g0 = cyc;
    drive(1'b1, 40);
    drive(1'b0, 2);
    drive(1'b1, 86);
    drive(1'b0, 128);
    period(128, 256);
    drive(1'b1, 8);
    drive(1'b0, 20);
    n_checks++; if (evq.size() != NEV) begin n_fail++; $display("FAIL glitch_count: got %0d expected %0d", evq.size(), NEV); end
    else begin
      for (int i = 0; i < NEV; i++) begin
        n_checks++; if (evq[i].cyc != g0 + exp_c[i]) begin n_fail++; $display("FAIL glitch_cycle[%0d]: got %0d expected %0d", i, evq[i].cyc, g0 + exp_c[i]); end
        n_checks++; if (evq[i].d !== exp_d[i] || evq[i].err !== exp_e[i] || evq[i].to !== 1'b0) begin n_fail++; $display("FAIL glitch_event[%0d]: got d=%0d err=%b to=%b expected %0d %b 0", i, evq[i].d, evq[i].err, evq[i].to, exp_d[i], exp_e[i]); end
      end
    end
    n_checks++; if (dbl_cnt != 0) begin n_fail++; $display("FAIL valid_width: got %0d multi-clk pulses expected 0", dbl_cnt); end
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_sweep();
    test_timeout_low();
    test_timeout_high();
    test_period_err();
    test_reset_mid();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Single-channel PWM demodulator, the receive end of the codebase's PWM link. It samples a PWM waveform on `pwm_in` and measures its high time and period in ticks of a prescaled internal clock. Once per PWM period it outputs a RES-bit duty value, giving the same code the PWM generator would have been fed. It is used for loopback checking of the synthesizer PWM outputs and for reading external PWM control inputs.

Parameters:
- RES, 8: duty resolution in bits; the nominal period is 2^RES ticks.
- FCLKM, 16000000: master clock frequency in Hz.
- FS, 10000: expected PWM frequency in Hz.
- DIV_N, derived localparam: clk cycles per tick = FCLKM/(FS*2^RES) when that is >1, else 1. Defaults give 6.
- TOL, 2: allowed period deviation in ticks before period_err is raised.

Ports:
- clk  input  1  master clock
- rst  input  1  synchronous, active-high reset
- pwm_in  input  1  asynchronous PWM input
- d_out  output  RES  last decoded duty code
- valid  output  1  one-clk pulse when d_out is updated
- period_err  output  1  measured period outside 2^RES±TOL; held until the next update
- timeout  output  1  no rising edge seen within 2^(RES+1) ticks; held until the next update

Behaviour:
- Reset: synchronous, active-high, one clk. Clears d_out=0, valid=0, period_err=0, timeout=0, synchroniser flops, prescaler, tick counters, and sets state=SYNC. Reset asserted mid-measurement discards the partial period.
- Input path: pwm_in passes through a 2-flop synchroniser, then a registered previous-level flop. rise = sync & ~prev.
- Prescaler: counts 0..DIV_N-1 and wraps; tick is high for one clk at the wrap. With DIV_N=1, tick is always high.
- Counters (advance only on tick):
  - per_cnt and hi_cnt are RES+2 bits wide.
  - hi_cnt increments when sync=1.
  - Both saturate at all-ones.
- State SYNC: wait for rise, ignoring ticks. On rise, clear counters and go to MEAS. This discards the first partial period after reset.
- State MEAS:
  - On rise, complete a measurement. In the clk after rise:
    - d_out = min(hi_cnt, 2^RES-1)
    - period_err = (|per_cnt - 2^RES| > TOL)
    - timeout = 0
    - valid = 1 for exactly one clk
  - Counters then restart at 0; the rise clk itself is not counted. Stay in MEAS.
  - If per_cnt reaches 2^(RES+1) with no rise (DC input):
    - d_out = 0 if sync=0, else 2^RES-1
    - timeout = 1, period_err = 0, valid pulse
    - Clear counters and stay in MEAS, so a timeout repeats every 2^(RES+1) ticks while the input is DC.
- Simultaneous rise and timeout threshold in the same clk: rise wins and a normal measurement is reported.
- Simultaneous rise and tick: the measurement uses the counter values before that tick's increment.
- Latency: valid fires 4 clk after the pwm_in rising edge (2 sync + 1 edge detect + 1 output register).
- Coding mapping: the generator code d gives d high ticks per 2^RES-tick period. Code 0 produces no rise, so it decodes via timeout to 0. Code 2^RES-1 decodes to 2^RES-1 with no error.

Optional Feature:
- Macro PWM_DEC_GLITCH_EN.
- When defined, a 3-clk stability filter sits after the synchroniser: the filtered level changes only after the synced input has held the new value for 3 consecutive clk. Latency becomes 7 clk and pulses shorter than 3 clk are ignored.
- When undefined, there is no filter, latency is 4 clk, and every synced edge counts.

Test Plan:
- Bench setup: FCLKM=2560000, FS=10000, so DIV_N=1. RES=8.
- Reset, then 3 periods of duty 64 (64 high / 192 low clk) → first period suppressed; valid pulses with d_out=64, period_err=0, each 4 clk after the rise.
- Duty sweep over 1, 128 and 255 → d_out=1, 128, 255, with one valid per period.
- Hold pwm_in=0 for 1200 clk → first timeout at 512 ticks after the last counter clear, d_out=0, timeout=1. Repeats every 512 ticks. Repeat with pwm_in=1 → d_out=255, timeout=1.
- Period of 270 clk with 100 high → d_out=100, period_err=1. Period of 258 → period_err=0.
- Assert rst for 1 clk mid-high-phase → all outputs 0 next clk; the next full period after resync is reported correctly.
- With PWM_DEC_GLITCH_EN defined, inject a 2-clk low glitch inside a duty-128 high phase → d_out=128, valid latency 7 clk. Without the macro, the same stimulus produces an extra short measurement.
